// File: rtl/cpu_step_controller.sv
// cpu_step_controller
//   Single-step / free-run controller for a pipelined CPU. A debounced push
//   button issues one advance pulse per press. A run switch issues a pulse
//   every RUN_DIV cycles. An optional PC breakpoint halts free-run.
//
// Build option:
//   CPU_STEP_BREAKPOINT_EN  define to enable the breakpoint/HALT feature.
//                           When it is undefined the bkpt_* and pc_fe ports
//                           are ignored and halted stays 0.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a button change
//   RUN_DIV          clk cycles per cpu_en pulse in RUN (2 .. 2^32-1)
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-high
//   step_btn    raw push-button (asynchronous)
//   run_sw      raw run-mode switch (asynchronous)
//   pc_fe       CPU fetch-stage PC
//   bkpt_addr   breakpoint PC
//   bkpt_valid  breakpoint armed
//   cpu_en      registered one-cycle advance pulse
//   halted      registered, high while in HALT
//   state       registered FSM state: IDLE=00 STEP=01 RUN=10 HALT=11
//   step_count  number of cpu_en pulses issued (wraps)
module cpu_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        run_sw,
  input  logic [31:0] pc_fe,
  input  logic [31:0] bkpt_addr,
  input  logic        bkpt_valid,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] step_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam int unsigned     DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     DIV_LAST = 32'(RUN_DIV - 1);

  // Synchronizers
  logic btn_meta_q, btn_sync_q;
  logic run_meta_q, run_sync_q;

  // Debouncer
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic            step_req;

  // FSM and datapath
  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic        halted_q, halted_d;
  logic [31:0] div_q, div_d;
  logic [31:0] step_count_q, step_count_d;
  logic        bkpt_hit;

`ifdef CPU_STEP_BREAKPOINT_EN
  assign bkpt_hit = bkpt_valid && (pc_fe == bkpt_addr);
`else
  // Breakpoint ports stay on the interface but feed nothing.
  logic unused_bkpt;
  assign unused_bkpt = ^{bkpt_valid, pc_fe, bkpt_addr};
  assign bkpt_hit    = 1'b0;
`endif

  // The counter tracks how many samples in a row disagree with the accepted
  // level; the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_sync_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign step_req = btn_db_q & ~btn_db_prev_q;

  // Next-state decision. The pulse decided here appears on cpu_en_q in the
  // following cycle, so suppression uses the inputs of the deciding cycle.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    div_d    = '0;
    case (state_q)
      ST_IDLE: begin
        // run_sw wins; a coincident step_req is dropped.
        if (run_sw_ok())      state_d = ST_RUN;
        else if (step_req)    begin state_d = ST_STEP; cpu_en_d = 1'b1; end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_RUN: begin
        if (!run_sync_q)      state_d = ST_IDLE;
        else if (bkpt_hit)    state_d = ST_HALT;
        else if (div_q == DIV_LAST) cpu_en_d = 1'b1;
        else                  div_d = div_q + 32'd1;
      end
      ST_HALT: begin
        if (!run_sync_q)      state_d = ST_IDLE;
        else if (step_req)    begin state_d = ST_STEP; cpu_en_d = 1'b1; end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CPU_STEP_BREAKPOINT_EN
    halted_d = (state_d == ST_HALT);
`else
    halted_d = 1'b0;
`endif
    step_count_d = step_count_q + {31'd0, cpu_en_d};
  end

  function automatic logic run_sw_ok();
    return run_sync_q;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      run_meta_q    <= 1'b0;
      run_sync_q    <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      state_q       <= ST_IDLE;
      cpu_en_q      <= 1'b0;
      halted_q      <= 1'b0;
      div_q         <= '0;
      step_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which is what lets the synchronizer chain be written in any order.
      btn_meta_q    <= step_btn;
      btn_sync_q    <= btn_meta_q;
      run_meta_q    <= run_sw;
      run_sync_q    <= run_meta_q;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      state_q       <= state_d;
      cpu_en_q      <= cpu_en_d;
      halted_q      <= halted_d;
      div_q         <= div_d;
      step_count_q  <= step_count_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign halted     = halted_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=3).
module tb_cpu_step_controller;

  localparam int DB  = 4;
  localparam int DIV = 3;
`ifdef CPU_STEP_BREAKPOINT_EN
  localparam bit BKPT_EN = 1'b1;
`else
  localparam bit BKPT_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_STEP = 1, M_RUN = 2, M_HALT = 3;

  logic        clk, reset, step_btn, run_sw, bkpt_valid;
  logic [31:0] pc_fe, bkpt_addr;
  logic        cpu_en, halted;
  logic [1:0]  state;
  logic [31:0] step_count;

  cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_btn   (step_btn),
    .run_sw     (run_sw),
    .pc_fe      (pc_fe),
    .bkpt_addr  (bkpt_addr),
    .bkpt_valid (bkpt_valid),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .state      (state),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs reach the control logic two clocks late; the button level flips
  // after DB disagreeing samples in a row; a request is the cycle after a
  // rising flip. In RUN a pulse falls on every DIV-th cycle spent there.
  bit          btn_pipe[$];
  bit          run_pipe[$];
  bit          m_level, m_level_prev;
  int          m_streak;
  int          m_mode;
  int          m_run_cycles;
  logic        m_cpu_en;
  logic [31:0] m_count;

  task automatic model_reset();
    btn_pipe = '{1'b0, 1'b0};
    run_pipe = '{1'b0, 1'b0};
    m_level = 1'b0; m_level_prev = 1'b0; m_streak = 0;
    m_mode = M_IDLE; m_run_cycles = 0; m_cpu_en = 1'b0; m_count = '0;
  endtask

  task automatic model_step();
    bit s_btn, s_run, req, hit, pulse;
    s_btn = btn_pipe.pop_front(); btn_pipe.push_back(step_btn);
    s_run = run_pipe.pop_front(); run_pipe.push_back(run_sw);
    req   = m_level && !m_level_prev;
    hit   = BKPT_EN && bkpt_valid && (pc_fe == bkpt_addr);
    pulse = 1'b0;
    case (m_mode)
      M_IDLE: if (s_run) begin m_mode = M_RUN; m_run_cycles = 0; end
              else if (req) m_mode = M_STEP;
      M_STEP: m_mode = M_IDLE;
      M_RUN:  if (!s_run) m_mode = M_IDLE;
              else if (hit) m_mode = M_HALT;
              else begin
                m_run_cycles++;
                pulse = (m_run_cycles % DIV) == 0;
              end
      default: if (!s_run) m_mode = M_IDLE;
               else if (req) m_mode = M_STEP;
    endcase
    if (m_mode == M_STEP) pulse = 1'b1;
    m_cpu_en = pulse;
    m_count  = m_count + 32'(pulse);
    m_level_prev = m_level;
    if (s_btn != m_level) begin
      m_streak++;
      if (m_streak == DB) begin m_level = s_btn; m_streak = 0; end
    end else begin
      m_streak = 0;
    end
  endtask

  // ---------------- cycle helpers ----------------
  int         pulse_cnt;
  logic [1:0] last_pulse_state;
  logic       prev_en;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cpu_en", {31'd0, cpu_en}, {31'd0, m_cpu_en});
    check("state", {30'd0, state}, 32'(m_mode));
    check("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
    check("step_count", step_count, m_count);
    check("cpu_en_back_to_back", {31'd0, cpu_en & prev_en}, 32'd0);
    if (cpu_en === 1'b1) begin
      pulse_cnt++;
      last_pulse_state = state;
    end
    prev_en = cpu_en;
  endtask

  // Called at a falling edge; reset spans one rising edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_step_count", step_count, 32'd0);
    model_reset();
    prev_en = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_hold_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        run;
    logic        btn;
    int          hold;
    logic [1:0]  exp_state;
    int          exp_pulses;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[14];
  int   btn_hold;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 10, 2'b00, 1, 32'd1};  // single press
    vecs[1]  = '{1'b0, 1'b0, 10, 2'b00, 0, 32'd1};  // release
    vecs[2]  = '{1'b1, 1'b0, 18, 2'b10, 5, 32'd6};  // RUN: pulses 3,6,... after entry
    vecs[3]  = '{1'b0, 1'b0, 10, 2'b00, 0, 32'd6};  // leave RUN, no more pulses
    vecs[4]  = '{1'b0, 1'b1,  1, 2'b00, 0, 32'd6};  // bounce 1
    vecs[5]  = '{1'b0, 1'b0,  1, 2'b00, 0, 32'd6};  // bounce 0
    vecs[6]  = '{1'b0, 1'b1,  1, 2'b00, 0, 32'd6};  // bounce 1
    vecs[7]  = '{1'b0, 1'b0,  1, 2'b00, 0, 32'd6};  // bounce 0
    vecs[8]  = '{1'b0, 1'b1, 10, 2'b00, 1, 32'd7};  // settle high: one pulse
    vecs[9]  = '{1'b0, 1'b0, 10, 2'b00, 0, 32'd7};
    vecs[10] = '{1'b0, 1'b1,  4, 2'b00, 0, 32'd7};  // press ahead of run_sw
    vecs[11] = '{1'b1, 1'b1,  3, 2'b10, 0, 32'd7};  // run_sw and step_req coincide
    vecs[12] = '{1'b0, 1'b1, 10, 2'b00, 0, 32'd7};  // dropped step never fires
    vecs[13] = '{1'b0, 1'b0, 10, 2'b00, 0, 32'd7};

    reset = 1'b0; step_btn = 1'b0; run_sw = 1'b0;
    pc_fe = '0; bkpt_addr = '0; bkpt_valid = 1'b0;
    pulse_cnt = 0; last_pulse_state = 2'b00; prev_en = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("init_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("init_halted", {31'd0, halted}, 32'd0);
    check("init_state", {30'd0, state}, 32'd0);
    check("init_step_count", step_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      run_sw = vecs[v].run;
      step_btn = vecs[v].btn;
      pulse_cnt = 0;
      repeat (vecs[v].hold) tick();
      check($sformatf("vec%0d_state", v), {30'd0, state}, {30'd0, vecs[v].exp_state});
      check($sformatf("vec%0d_pulses", v), 32'(pulse_cnt), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d_count", v), step_count, vecs[v].exp_count);
    end

    // Breakpoint behaviour
`ifdef CPU_STEP_BREAKPOINT_EN
    bkpt_addr = 32'h10; bkpt_valid = 1'b1; pc_fe = 32'h0; run_sw = 1'b1;
    pulse_cnt = 0;
    repeat (4) tick();
    check("bkpt_pre_state", {30'd0, state}, 32'd2);
    pc_fe = 32'h10;
    tick();
    check("bkpt_halt_state", {30'd0, state}, 32'd3);
    check("bkpt_halted", {31'd0, halted}, 32'd1);
    check("bkpt_match_no_pulse", 32'(pulse_cnt), 32'd0);
    step_btn = 1'b1;
    repeat (15) tick();
    check("bkpt_step_pulses", 32'(pulse_cnt), 32'd1);
    check("bkpt_step_pulse_state", {30'd0, last_pulse_state}, 32'd1);
    check("bkpt_rehalt_state", {30'd0, state}, 32'd3);
    step_btn = 1'b0;
    repeat (10) tick();
    check("bkpt_release_state", {30'd0, state}, 32'd3);
    run_sw = 1'b0;
    repeat (4) tick();
    check("bkpt_exit_state", {30'd0, state}, 32'd0);
    check("bkpt_exit_halted", {31'd0, halted}, 32'd0);
    bkpt_valid = 1'b0; pc_fe = 32'h0;
`else
    bkpt_addr = 32'h10; bkpt_valid = 1'b1; pc_fe = 32'h10; run_sw = 1'b1;
    pulse_cnt = 0;
    repeat (12) tick();
    check("nobkpt_run_pulses", 32'(pulse_cnt), 32'd3);
    check("nobkpt_state", {30'd0, state}, 32'd2);
    check("nobkpt_halted", {31'd0, halted}, 32'd0);
    run_sw = 1'b0;
    repeat (10) tick();
    check("nobkpt_exit_state", {30'd0, state}, 32'd0);
    check("nobkpt_exit_pulses", 32'(pulse_cnt), 32'd3);
`endif

    // step_count wrap: preload all-ones, then one more step
    force dut.step_count_d = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    release dut.step_count_d;
    check("wrap_preload", step_count, 32'hFFFF_FFFF);
    step_btn = 1'b1;
    repeat (10) tick();
    check("wrap_to_zero", step_count, 32'd0);
    step_btn = 1'b0;
    repeat (10) tick();

    // Reset one cycle before a RUN divider pulse
    if (!BKPT_EN) begin
      bkpt_valid = 1'b1; pc_fe = bkpt_addr;
    end
    run_sw = 1'b1;
    repeat (5) tick();
    check("midrun_state", {30'd0, state}, 32'd2);
    do_reset();
    check("post_reset_state", {30'd0, state}, 32'd0);
    pulse_cnt = 0;
    repeat (10) tick();
    check("post_reset_pulses", 32'(pulse_cnt), 32'd2);
    check("post_reset_halted", {31'd0, halted}, 32'd0);
    run_sw = 1'b0;
    repeat (6) tick();
    bkpt_valid = 1'b0;

    // Randomized traffic against the model, with occasional resets
    bkpt_addr = $urandom();
    btn_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (btn_hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        btn_hold = int'($urandom_range(1, 12));
      end else begin
        btn_hold--;
      end
      if ($urandom_range(0, 49) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 9) == 0) bkpt_valid = ~bkpt_valid;
      pc_fe = ($urandom_range(0, 3) == 0) ? bkpt_addr : $urandom();
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable samples needed to accept a step_btn level change.
REQ-002 The block SHALL have parameter RUN_DIV, default 25000000: clk cycles per cpu_en pulse in RUN; legal range 2..2^32-1.
REQ-003 The block SHALL have port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port step_btn  input  1  raw, asynchronous push-button, active-high.
REQ-006 The block SHALL have port run_sw  input  1  raw, asynchronous run-mode switch, active-high.
REQ-007 The block SHALL have port pc_fe  input  32  CPU fetch-stage PC.
REQ-008 The block SHALL have port bkpt_addr  input  32  breakpoint PC.
REQ-009 The block SHALL have port bkpt_valid  input  1  breakpoint armed.
REQ-010 The block SHALL have port cpu_en  output  1  one-cycle advance pulse that gates the CPU pipeline.
REQ-011 The block SHALL have port halted  output  1  high while in HALT.
REQ-012 The block SHALL have port state  output  2  FSM state: IDLE=00, STEP=01, RUN=10, HALT=11.
REQ-013 The block SHALL have port step_count  output  32  count of cpu_en pulses issued.

Function
REQ-014 step_btn and run_sw SHALL each pass through a 2-flop synchronizer before any other logic uses them.
REQ-015 The debounced button SHALL change level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from its current level; any matching sample SHALL clear the debounce counter.
REQ-016 A rising edge of the debounced button SHALL produce step_req, high for exactly one cycle.
REQ-017 IDLE: if synchronized run_sw=1, the next state SHALL be RUN; else if step_req=1, STEP; else stay in IDLE. run_sw has priority and a coincident step_req is discarded.
REQ-018 STEP SHALL last one cycle, drive cpu_en=1, then return to IDLE.
REQ-019 RUN: a divider SHALL count 0..RUN_DIV-1 and wrap; cpu_en SHALL be 1 only in the cycle the divider equals RUN_DIV-1. The first pulse occurs RUN_DIV cycles after RUN entry.
REQ-020 RUN: if synchronized run_sw=0, the next state SHALL be IDLE with no pulse in that cycle. The divider SHALL clear whenever the state is not RUN.
REQ-021 RUN: a breakpoint match (bkpt_valid=1 and pc_fe==bkpt_addr) SHALL move the FSM to HALT and suppress cpu_en in that cycle. Priority order is run_sw=0, then match, then divider pulse.
REQ-022 HALT: if run_sw=0, the next state SHALL be IDLE; else if step_req=1, STEP; else stay in HALT. step_req in HALT is how the CPU advances past the breakpoint.
REQ-023 Entering RUN while pc_fe already matches SHALL halt in the first RUN cycle. This is intended behaviour.
REQ-024 step_count SHALL increment by 1 on every cycle with cpu_en=1 and wrap from 0xFFFFFFFF to 0.
REQ-025 cpu_en SHALL never be high for two consecutive cycles.
REQ-026 halted SHALL equal (state==11), and cpu_en, halted and state SHALL be registered outputs.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, cpu_en=0, halted=0, step_count=0, divider=0, debounce counters=0, debounced levels=0, synchronizers=0.
REQ-028 Reset asserted mid-RUN or mid-debounce SHALL abort the operation with no cpu_en pulse. After release, operation SHALL resume from IDLE on the first clk edge.

Configuration
REQ-029 Macro CPU_STEP_BREAKPOINT_EN SHALL control the breakpoint feature.
REQ-030 With CPU_STEP_BREAKPOINT_EN defined, REQ-021 through REQ-023 SHALL apply.
REQ-031 Without CPU_STEP_BREAKPOINT_EN, the breakpoint ports SHALL remain present but be ignored, HALT SHALL be unreachable, and halted SHALL stay constant 0.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=3, macro defined unless noted)
REQ-032 Press step_btn for 10 cycles in IDLE -> exactly one cpu_en pulse, step_count=1, state returns to 00.
REQ-033 step_btn bounces 1-0-1-0 on 1-cycle intervals, then stays high 10 cycles -> exactly one cpu_en pulse.
REQ-034 run_sw=1 for 20 cycles with no breakpoint -> cpu_en pulses every 3rd cycle, first pulse 3 cycles after RUN entry; then run_sw=0 -> state=00 and no further pulses.
REQ-035 RUN with bkpt_valid=1, bkpt_addr=0x10, pc_fe driven 0x0 then 0x10 -> state=11, halted=1, no cpu_en in the match cycle. A step press then gives one pulse, state 01 then 11; run_sw=0 then gives 00.
REQ-036 Preload step_count=0xFFFFFFFF via forced steps; issue one more step -> step_count=0.
REQ-037 Assert reset mid-RUN one cycle before a divider pulse -> no pulse, all outputs 0. Repeat with the macro undefined and pc_fe==bkpt_addr -> halted stays 0 and RUN pulses continue.
